// File: rtl/spu_pkg.sv
// Shared opcode/state encodings and spu_code field positions for the equalizer engine.
package spu_pkg;

  localparam int unsigned SPU_OP_MSB  = 11;
  localparam int unsigned SPU_OP_LSB  = 8;
  localparam int unsigned SPU_ARG_MSB = 7;
  localparam int unsigned SPU_ARG_LSB = 0;

  typedef enum logic [3:0] {
    SPU_NOP  = 4'h0,
    SPU_HIST = 4'h1,
    SPU_CDF  = 4'h2,
    SPU_MAP  = 4'h3,
    SPU_FILL = 4'h4
  } spu_op_e;

  typedef enum logic [3:0] {
    StIdle,
    StClear,
    StScan,
    StDrain,
    StPrefix,
    StMapRd,
    StMapWr,
    StFill,
    StFin
  } spu_state_e;

  function automatic logic spu_op_legal(logic [3:0] op);
    return op <= SPU_FILL;
  endfunction

endpackage

// File: rtl/spu_pixel_addr_gen.sv
// Pixel address counter with terminal-count flag and a one-cycle delayed copy for write-back.
module spu_pixel_addr_gen #(
  parameter int unsigned PIX_AW = 12
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              en_i,
  output logic [PIX_AW-1:0] addr_o,
  output logic [PIX_AW-1:0] addr_dly_o,
  output logic              tc_o
);

  logic [PIX_AW-1:0] addr_q, addr_dly_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      addr_q     <= '0;
      addr_dly_q <= '0;
    end else begin
      addr_dly_q <= addr_q;
      if (start_i) begin
        addr_q <= '0;
      end else if (en_i) begin
        addr_q <= addr_q + 1'b1;
      end
    end
  end

  assign addr_o     = addr_q;
  assign addr_dly_o = addr_dly_q;
  assign tc_o       = (addr_q == '1);

endmodule

// File: rtl/spu_equalizer_engine.sv
// Histogram-equalisation unit: HIST, CDF, MAP and FILL passes over an 8-bit pixel memory,
// holding busy_o high so the core stalls until the pass finishes.
module spu_equalizer_engine
  import spu_pkg::*;
#(
  parameter int unsigned PIX_AW = 12,
  parameter int unsigned CNT_W  = PIX_AW + 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              spu_valid_i,
  input  logic [11:0]       spu_code_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              overrun_o,
  output logic [PIX_AW-1:0] mem_raddr_o,
  input  logic [7:0]        mem_rdata_i,
  output logic [PIX_AW-1:0] mem_waddr_o,
  output logic [7:0]        mem_wdata_o,
  output logic              mem_we_o
);

  localparam int unsigned      NPIX    = 1 << PIX_AW;
  localparam logic [CNT_W-1:0] HistSat = CNT_W'(NPIX);

  spu_state_e        state_q, state_d;
  logic [3:0]        op_q;
  logic [7:0]        arg_q, bin_q;
  logic              rd_vld_q, done_q, err_q, overrun_q;
  logic [CNT_W-1:0]  hist_q [256];
  logic [CNT_W-1:0]  cdf_q  [256];
  logic              accept, addr_en, addr_tc, map_wr;
  logic [PIX_AW-1:0] addr, addr_dly;
  logic [CNT_W-1:0]  cdf_prev;
  logic [7:0]        map_pix;

  assign accept  = (state_q == StIdle) && spu_valid_i;
  assign addr_en = state_q inside {StScan, StMapRd, StFill};

  spu_pixel_addr_gen #(
    .PIX_AW(PIX_AW)
  ) u_addr_gen (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .start_i   (accept),
    .en_i      (addr_en),
    .addr_o    (addr),
    .addr_dly_o(addr_dly),
    .tc_o      (addr_tc)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (spu_valid_i) begin
          case (spu_code_i[SPU_OP_MSB:SPU_OP_LSB])
            SPU_HIST: state_d = StClear;
            SPU_CDF:  state_d = StPrefix;
            SPU_MAP:  state_d = StMapRd;
            SPU_FILL: state_d = StFill;
            default:  state_d = StFin;
          endcase
        end
      end
      StClear:  state_d = StScan;
      StScan:   if (addr_tc) state_d = StDrain;
      StDrain:  state_d = StFin;
      StPrefix: if (bin_q == 8'hFF) state_d = StFin;
      StMapRd:  if (addr_tc) state_d = StMapWr;
      StMapWr:  state_d = StFin;
      StFill:   if (addr_tc) state_d = StFin;
      StFin:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      op_q      <= '0;
      arg_q     <= '0;
      bin_q     <= '0;
      rd_vld_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < 256; i++) begin
        hist_q[i] <= '0;
        cdf_q[i]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      done_q   <= (state_q == StFin);
      err_q    <= (state_q == StFin) && !spu_op_legal(op_q);
      // Read data returns one cycle after the address issues.
      rd_vld_q <= (state_q == StScan) || (state_q == StMapRd);
      if (spu_valid_i && (state_q != StIdle)) overrun_q <= 1'b1;
      if (accept) begin
        op_q  <= spu_code_i[SPU_OP_MSB:SPU_OP_LSB];
        arg_q <= spu_code_i[SPU_ARG_MSB:SPU_ARG_LSB];
        bin_q <= '0;
      end
      if (state_q == StPrefix) begin
        bin_q        <= bin_q + 8'd1;
        cdf_q[bin_q] <= cdf_prev + hist_q[bin_q];
      end
      if (state_q == StClear) begin
        for (int i = 0; i < 256; i++) hist_q[i] <= '0;
      end else if (rd_vld_q && (op_q == SPU_HIST) && (hist_q[mem_rdata_i] != HistSat)) begin
        hist_q[mem_rdata_i] <= hist_q[mem_rdata_i] + 1'b1;
      end
    end
  end

  always_comb begin
    map_wr      = rd_vld_q && (op_q == SPU_MAP);
    cdf_prev    = (bin_q == 8'd0) ? '0 : cdf_q[bin_q - 8'd1];
    map_pix     = 8'(((CNT_W + 8)'(cdf_q[mem_rdata_i]) * (CNT_W + 8)'(255)) >> PIX_AW);
    mem_we_o    = 1'b0;
    mem_waddr_o = '0;
    mem_wdata_o = '0;
    if (state_q == StFill) begin
      mem_we_o    = 1'b1;
      mem_waddr_o = addr;
      mem_wdata_o = arg_q;
    end else if (map_wr) begin
      mem_we_o    = 1'b1;
      mem_waddr_o = addr_dly;
      mem_wdata_o = map_pix;
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign overrun_o   = overrun_q;
  assign mem_raddr_o = addr;

endmodule

// File: tb/tb_spu_equalizer_engine.sv
// Directed-plus-random bench for spu_equalizer_engine with a 16-pixel memory and reference model.
module tb_spu_equalizer_engine;
  import spu_pkg::*;

  localparam int unsigned PIX_AW = 4;
  localparam int unsigned CNT_W  = PIX_AW + 1;
  localparam int          NPIX   = 16;

  logic              clk_i = 1'b0;
  logic              reset_i = 1'b1;
  logic              spu_valid_i = 1'b0;
  logic [11:0]       spu_code_i = '0;
  logic              busy_o, done_o, err_o, overrun_o, mem_we_o;
  logic [PIX_AW-1:0] mem_raddr_o, mem_waddr_o;
  logic [7:0]        mem_rdata_i, mem_wdata_o;

  logic [7:0] mem     [NPIX];
  logic [7:0] ld_img  [NPIX];
  logic [7:0] exp_img [NPIX];
  logic       ld_en = 1'b0;
  int         exp_hist [256];
  int         exp_cdf  [256];
  int         n_pass = 0, n_total = 0;
  int         busy_cyc, we_cyc, done_cnt, err_cnt, lag_bad;
  logic [1:0] end_de;
  bit         tmo;

  spu_equalizer_engine #(
    .PIX_AW(PIX_AW),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .spu_valid_i(spu_valid_i),
    .spu_code_i (spu_code_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .overrun_o  (overrun_o),
    .mem_raddr_o(mem_raddr_o),
    .mem_rdata_i(mem_rdata_i),
    .mem_waddr_o(mem_waddr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_we_o   (mem_we_o)
  );

  always #5 clk_i = ~clk_i;

  // Dual-port pixel memory, synchronous read; ld_en is a bench backdoor for image loading.
  always @(posedge clk_i) begin
    mem_rdata_i <= mem[mem_raddr_o];
    if (ld_en) mem <= ld_img;
    else if (mem_we_o) mem[mem_waddr_o] <= mem_wdata_o;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic load_image();
    @(negedge clk_i);
    ld_en = 1'b1;
    @(negedge clk_i);
    ld_en = 1'b0;
    for (int p = 0; p < NPIX; p++) exp_img[p] = ld_img[p];
  endtask

  // Issues one instruction and measures the pass; optionally pokes spu_valid mid-pass.
  task automatic run_op(input logic [11:0] code, input int poke_at, input logic [11:0] poke_code);
    logic [PIX_AW-1:0] prev_raddr;
    int n;
    busy_cyc = 0; we_cyc = 0; done_cnt = 0; err_cnt = 0; lag_bad = 0; n = 0;
    @(negedge clk_i);
    spu_valid_i = 1'b1;
    spu_code_i  = code;
    @(negedge clk_i);
    spu_valid_i = 1'b0;
    prev_raddr  = mem_raddr_o;
    while (busy_o && n < 400) begin
      busy_cyc++;
      if (mem_we_o) begin
        we_cyc++;
        if (mem_waddr_o != prev_raddr) lag_bad++;
      end
      if (done_o) done_cnt++;
      if (err_o) err_cnt++;
      prev_raddr  = mem_raddr_o;
      spu_code_i  = (n == poke_at) ? poke_code : 12'($urandom);
      spu_valid_i = (n == poke_at);
      @(negedge clk_i);
      n++;
    end
    spu_valid_i = 1'b0;
    tmo    = (n >= 400);
    end_de = {done_o, err_o};
    if (done_o) done_cnt++;
    if (err_o) err_cnt++;
    if (mem_we_o) we_cyc++;
    @(negedge clk_i);
    if (done_o) done_cnt++;
    if (err_o) err_cnt++;
  endtask

  task automatic model_hist();
    for (int i = 0; i < 256; i++) exp_hist[i] = 0;
    for (int p = 0; p < NPIX; p++) exp_hist[exp_img[p]]++;
  endtask

  task automatic model_cdf();
    int s = 0;
    for (int i = 0; i < 256; i++) begin
      s += exp_hist[i];
      exp_cdf[i] = s;
    end
  endtask

  task automatic model_map();
    for (int p = 0; p < NPIX; p++) exp_img[p] = 8'((exp_cdf[exp_img[p]] * 255) / NPIX);
  endtask

  function automatic int hist_diff();
    int d = 0;
    for (int i = 0; i < 256; i++) if (int'(dut.hist_q[i]) != exp_hist[i]) d++;
    return d;
  endfunction

  function automatic int cdf_diff();
    int d = 0;
    for (int i = 0; i < 256; i++) if (int'(dut.cdf_q[i]) != exp_cdf[i]) d++;
    return d;
  endfunction

  function automatic int nonzero_bins();
    int d = 0;
    for (int i = 0; i < 256; i++) if (dut.hist_q[i] != '0 || dut.cdf_q[i] != '0) d++;
    return d;
  endfunction

  function automatic int img_diff();
    int d = 0;
    for (int p = 0; p < NPIX; p++) if (mem[p] !== exp_img[p]) d++;
    return d;
  endfunction

  task automatic run_equalize(input string tag);
    model_hist();
    run_op(12'h100, -1, 12'h0);
    chk({tag, " hist busy"}, busy_cyc, NPIX + 3);
    chk({tag, " hist bins"}, hist_diff(), 0);
    model_cdf();
    run_op(12'h200, -1, 12'h0);
    chk({tag, " cdf busy"}, busy_cyc, 257);
    chk({tag, " cdf entries"}, cdf_diff(), 0);
    model_map();
    run_op(12'h300, -1, 12'h0);
    chk({tag, " map busy"}, busy_cyc, NPIX + 2);
    chk({tag, " map writes"}, we_cyc, NPIX);
    chk({tag, " map addr lag"}, lag_bad, 0);
    chk({tag, " map pixels"}, img_diff(), 0);
    chk({tag, " timeout"}, tmo, 0);
  endtask

  initial begin
    int k, tmp, hi;
    repeat (3) @(negedge clk_i);
    chk("rst busy", busy_o, 0);
    chk("rst done", done_o, 0);
    chk("rst err", err_o, 0);
    chk("rst overrun", overrun_o, 0);
    chk("rst we", mem_we_o, 0);
    chk("rst addrs", {mem_raddr_o, mem_waddr_o, mem_wdata_o}, 0);
    chk("rst tables", nonzero_bins(), 0);
    reset_i = 1'b0;

    // FILL 0x4A
    run_op(12'h44A, -1, 12'h0);
    for (int p = 0; p < NPIX; p++) exp_img[p] = 8'h4A;
    chk("fill busy", busy_cyc, NPIX + 1);
    chk("fill writes", we_cyc, NPIX);
    chk("fill done", done_cnt, 1);
    chk("fill err", err_cnt, 0);
    chk("fill end", end_de, 2'b10);
    chk("fill pixels", img_diff(), 0);

    // HIST of an all-7 image
    for (int p = 0; p < NPIX; p++) ld_img[p] = 8'd7;
    load_image();
    run_op(12'h1FF, -1, 12'h0);
    chk("hist7 busy", busy_cyc, NPIX + 3);
    chk("hist7 writes", we_cyc, 0);
    chk("hist7 bin7", dut.hist_q[7], NPIX);
    model_hist();
    chk("hist7 bins", hist_diff(), 0);

    // Half 0, half 255, shuffled
    for (int p = 0; p < NPIX; p++) ld_img[p] = (p < NPIX / 2) ? 8'd0 : 8'd255;
    for (int p = NPIX - 1; p > 0; p--) begin
      k = $urandom_range(0, p);
      tmp = ld_img[p]; ld_img[p] = ld_img[k]; ld_img[k] = 8'(tmp);
    end
    load_image();
    run_equalize("split");
    chk("split cdf0", dut.cdf_q[0], 8);
    chk("split cdf254", dut.cdf_q[254], 8);
    chk("split cdf255", dut.cdf_q[255], 16);
    k = 0;
    for (int p = 0; p < NPIX; p++) if (mem[p] == 8'd127) k++;
    chk("split px127", k, NPIX / 2);

    // Random images with increasing value spread
    for (int it = 0; it < 3; it++) begin
      hi = (it == 0) ? 3 : (it == 1) ? 40 : 255;
      for (int p = 0; p < NPIX; p++) ld_img[p] = 8'($urandom_range(0, hi));
      load_image();
      run_equalize($sformatf("rand%0d", it));
    end

    // Illegal opcode and NOP
    run_op(12'hF5A, -1, 12'h0);
    chk("ill busy", busy_cyc, 1);
    chk("ill end", end_de, 2'b11);
    chk("ill pulses", {done_cnt[3:0], err_cnt[3:0]}, 8'h11);
    chk("ill writes", we_cyc, 0);
    run_op(12'h0AA, -1, 12'h0);
    chk("nop busy", busy_cyc, 1);
    chk("nop end", end_de, 2'b10);

    // spu_valid during FILL is ignored but flags overrun
    chk("ovr before", overrun_o, 0);
    run_op(12'h433, 5, 12'h1FF);
    for (int p = 0; p < NPIX; p++) exp_img[p] = 8'h33;
    chk("ovr fill busy", busy_cyc, NPIX + 1);
    chk("ovr fill writes", we_cyc, NPIX);
    chk("ovr fill pixels", img_diff(), 0);
    chk("ovr set", overrun_o, 1);
    run_op(12'h000, -1, 12'h0);
    chk("ovr sticky", overrun_o, 1);

    // Reset mid-SCAN of HIST
    for (int p = 0; p < NPIX; p++) ld_img[p] = 8'($urandom_range(0, 255));
    load_image();
    @(negedge clk_i);
    spu_valid_i = 1'b1; spu_code_i = 12'h100;
    @(negedge clk_i);
    spu_valid_i = 1'b0;
    repeat (8) @(negedge clk_i);
    reset_i = 1'b1;
    #1;
    chk("rscan busy", busy_o, 0);
    chk("rscan we", mem_we_o, 0);
    chk("rscan overrun", overrun_o, 0);
    chk("rscan tables", nonzero_bins(), 0);
    @(negedge clk_i);
    reset_i = 1'b0;

    // Reset mid-FILL drops the write strobe at once
    @(negedge clk_i);
    spu_valid_i = 1'b1; spu_code_i = 12'h4C3;
    @(negedge clk_i);
    spu_valid_i = 1'b0;
    repeat (4) @(negedge clk_i);
    chk("rfill we before", mem_we_o, 1);
    reset_i = 1'b1;
    #1;
    chk("rfill busy", busy_o, 0);
    chk("rfill we", mem_we_o, 0);
    @(negedge clk_i);
    reset_i = 1'b0;

    run_op(12'h45C, -1, 12'h0);
    for (int p = 0; p < NPIX; p++) exp_img[p] = 8'h5C;
    chk("post fill busy", busy_cyc, NPIX + 1);
    chk("post fill pixels", img_diff(), 0);

    // MAP with cleared CDF writes zeros everywhere
    run_op(12'h300, -1, 12'h0);
    for (int p = 0; p < NPIX; p++) exp_img[p] = 8'h00;
    chk("map0 writes", we_cyc, NPIX);
    chk("map0 pixels", img_diff(), 0);
    chk("final timeout", tmo, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
